regfile_bypass_sb: RTL and testbench

//  Parametrised multi-read-port integer register file for the pipelined core, successor to the 32x32 2R1W file.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 68 ++++++
 rtl/regfile_bypass_sb.sv | 83 ++++++++
 tb/tb_regfile_bypass_sb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults for the bypassing register file and its busy scoreboard.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DEPTH  = 1 << RF_ADDR_W;

  // Index of the hardwired zero register.
  localparam int RF_ZERO_IDX = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one busy bit per register, set by reserve, cleared by
// write. Reserve beats clear on the same index so the newest producer owns
// the register. Provides a per-read-port busy lookup and a registered any_busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     any_busy
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(RF_ZERO_IDX);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busyNext;
  logic             r_anyBusy;
  logic             w_clrOk;
  logic             w_rsvOk;

  // Drop clears and reserves aimed at the hardwired zero register.
  always_comb begin
    w_clrOk = clr_en && !((ZERO_REG != 0) && (clr_addr == ZERO_IDX));
    w_rsvOk = rsv_en && !((ZERO_REG != 0) && (rsv_addr == ZERO_IDX));
  end

  // Next busy vector: apply the clear first so a same-index reserve wins.
  always_comb begin
    w_busyNext = r_busy;
    if (w_clrOk) begin
      w_busyNext[clr_addr] = 1'b0;
    end
    if (w_rsvOk) begin
      w_busyNext[rsv_addr] = 1'b1;
    end
  end

  // Busy state and its OR, both taken from the next-state vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_anyBusy <= 1'b0;
    end else begin
      r_busy    <= w_busyNext;
      r_anyBusy <= |w_busyNext;
    end
  end

  assign any_busy = r_anyBusy;

  // Per-port lookup of the registered busy bits; the zero register never reports busy.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [ADDR_W-1:0] w_addr;
    assign w_addr     = rd_addr[p*ADDR_W +: ADDR_W];
    assign rd_busy[p] = ((ZERO_REG != 0) && (w_addr == ZERO_IDX)) ? 1'b0 : r_busy[w_addr];
  end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Multi-read-port integer register file with async clear, optional hardwired
// zero register, optional same-cycle write-to-read bypass and a busy
// scoreboard so decode can stall on registers owned by in-flight producers.
module regfile_bypass_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     any_busy
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(RF_ZERO_IDX);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wrOk;
  logic              w_wrLive;
  logic [NUM_RD-1:0] w_sbBusy;

  // A write is stored unless it targets the hardwired zero register; while
  // reset is held the write is lost, so it must not be forwarded either.
  always_comb begin
    w_wrOk   = wr_en && !((ZERO_REG != 0) && (wr_addr == ZERO_IDX));
    w_wrLive = wr_en && rst_n;
  end

  // Data array: async clear of every entry, otherwise a single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wrOk) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (w_sbBusy),
    .any_busy (any_busy)
  );

  // Read ports: zero register first, then the bypass hit, then stored state.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_rdAddr;
    logic              w_isZero;
    logic              w_hit;

    assign w_rdAddr = rd_addr[p*ADDR_W +: ADDR_W];
    assign w_isZero = (ZERO_REG != 0) && (w_rdAddr == ZERO_IDX);
    assign w_hit    = (BYPASS != 0) && w_wrLive && (wr_addr == w_rdAddr) && !w_isZero;

    assign rd_data[p*DATA_W +: DATA_W] = w_isZero ? '0 : (w_hit ? wr_data : r_mem[w_rdAddr]);
    assign rd_busy[p]                  = w_hit ? 1'b0 : w_sbBusy[p];
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Self-checking bench for regfile_bypass_sb. Four 3-port instances cover every
// ZERO_REG/BYPASS combination; all share the same stimulus and are compared
// against a per-instance array model of the register file rules.
module tb_regfile_bypass_sb;

  localparam int NDUT = 4;
  localparam int NRD  = 3;

  logic        clk;
  logic        rst_n;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic        rsvEn;
  logic [4:0]  rsvAddr;
  logic [4:0]  rdAddr [NRD];
  logic [14:0] rdAddrBus;

  logic [NRD*32-1:0] rdData  [NDUT];
  logic [NRD-1:0]    rdBusy  [NDUT];
  logic              anyBusy [NDUT];

  logic [31:0] mReg  [NDUT][32];
  bit          mBusy [NDUT][32];

  int assertCount = 0;
  int failCount   = 0;

  assign rdAddrBus = {rdAddr[2], rdAddr[1], rdAddr[0]};

  // Instance k: 0 = zero reg + bypass, 1 = neither, 2 = zero reg only, 3 = bypass only.
  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    regfile_bypass_sb #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .NUM_RD   (NRD),
      .ZERO_REG ((k == 0 || k == 2) ? 1 : 0),
      .BYPASS   ((k == 0 || k == 3) ? 1 : 0)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wrEn),
      .wr_addr  (wrAddr),
      .wr_data  (wrData),
      .rsv_en   (rsvEn),
      .rsv_addr (rsvAddr),
      .rd_addr  (rdAddrBus),
      .rd_data  (rdData[k]),
      .rd_busy  (rdBusy[k]),
      .any_busy (anyBusy[k])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit hasZero(int k);
    return (k == 0 || k == 2);
  endfunction

  function automatic bit hasBypass(int k);
    return (k == 0 || k == 3);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] portData(int k, int p);
    return rdData[k][p*32 +: 32];
  endfunction

  task automatic clearModel();
    for (int k = 0; k < NDUT; k++) begin
      for (int a = 0; a < 32; a++) begin
        mReg[k][a]  = '0;
        mBusy[k][a] = 1'b0;
      end
    end
  endtask

  // Compare every read port and any_busy of every instance with the model,
  // using the inputs currently applied (for the bypass path).
  task automatic compareModel(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      bit anyExp = 1'b0;
      for (int a = 0; a < 32; a++) anyExp |= mBusy[k][a];
      for (int p = 0; p < NRD; p++) begin
        int          a      = int'(rdAddr[p]);
        logic [31:0] expD;
        bit          expB;
        if (hasZero(k) && a == 0) begin
          expD = '0;
          expB = 1'b0;
        end else if (hasBypass(k) && wrEn && int'(wrAddr) == a) begin
          expD = wrData;
          expB = 1'b0;
        end else begin
          expD = mReg[k][a];
          expB = mBusy[k][a];
        end
        checkOutput($sformatf("%s d%0d p%0d data", tag, k, p), portData(k, p), expD);
        checkOutput($sformatf("%s d%0d p%0d busy", tag, k, p), {31'b0, rdBusy[k][p]}, {31'b0, expB});
      end
      checkOutput($sformatf("%s d%0d any_busy", tag, k), {31'b0, anyBusy[k]}, {31'b0, anyExp});
    end
  endtask

  // Apply the rising-edge rules: write stores and frees, reserve then marks busy.
  task automatic updateModel();
    for (int k = 0; k < NDUT; k++) begin
      if (wrEn && !(hasZero(k) && wrAddr == 5'd0)) begin
        mReg[k][wrAddr]  = wrData;
        mBusy[k][wrAddr] = 1'b0;
      end
      if (rsvEn && !(hasZero(k) && rsvAddr == 5'd0)) begin
        mBusy[k][rsvAddr] = 1'b1;
      end
    end
  endtask

  // Called at a falling edge: drive inputs, then check the combinational reads.
  task automatic applyStimulus(input string tag, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic re, input logic [4:0] ra,
                               input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    wrEn      = we;
    wrAddr    = wa;
    wrData    = wd;
    rsvEn     = re;
    rsvAddr   = ra;
    rdAddr[0] = a0;
    rdAddr[1] = a1;
    rdAddr[2] = a2;
    #1;
    compareModel(tag);
  endtask

  task automatic endCycle();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  function automatic logic [4:0] randAddr();
    int sel = $urandom_range(0, 7);
    if (sel == 0) return 5'd0;
    if (sel == 1) return 5'd31;
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rst_n   = 1'b0;
    wrEn    = 1'b0;
    wrAddr  = '0;
    wrData  = '0;
    rsvEn   = 1'b0;
    rsvAddr = '0;
    for (int p = 0; p < NRD; p++) rdAddr[p] = 5'd0;
    clearModel();

    #2;
    compareModel("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] write r9=66, same-cycle and next-cycle reads");
    applyStimulus("wr9", 1'b1, 5'd9, 32'd66, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9);
    checkOutput("wr9 bypass d0", portData(0, 0), 32'd66);
    checkOutput("wr9 nobypass d1", portData(1, 0), 32'd0);
    endCycle();
    applyStimulus("rd9", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9);
    checkOutput("rd9 d1 p1", portData(1, 1), 32'd66);
    checkOutput("rd9 d2 p2", portData(2, 2), 32'd66);
    endCycle();

    $display("[TB] scoreboard reserve then write r10");
    applyStimulus("rsv10", 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd10, 5'd10, 5'd9);
    checkOutput("rsv10 not forwarded", {31'b0, rdBusy[0][0]}, 32'd0);
    endCycle();
    applyStimulus("wr10", 1'b1, 5'd10, 32'd4, 1'b0, 5'd0, 5'd10, 5'd10, 5'd10);
    for (int k = 0; k < NDUT; k++) checkOutput($sformatf("wr10 any d%0d", k), {31'b0, anyBusy[k]}, 32'd1);
    checkOutput("wr10 bypass busy", {31'b0, rdBusy[0][0]}, 32'd0);
    checkOutput("wr10 bypass data", portData(0, 0), 32'd4);
    checkOutput("wr10 nobypass busy", {31'b0, rdBusy[1][0]}, 32'd1);
    endCycle();
    applyStimulus("after10", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10, 5'd10, 5'd10);
    for (int k = 0; k < NDUT; k++) checkOutput($sformatf("after10 any d%0d", k), {31'b0, anyBusy[k]}, 32'd0);
    checkOutput("after10 d1 data", portData(1, 0), 32'd4);
    endCycle();

    $display("[TB] same-edge write and reserve collisions");
    applyStimulus("col19", 1'b1, 5'd19, 32'd5, 1'b1, 5'd19, 5'd19, 5'd19, 5'd19);
    endCycle();
    applyStimulus("rd19", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd19, 5'd19, 5'd19);
    checkOutput("rd19 data", portData(0, 1), 32'd5);
    checkOutput("rd19 busy", {31'b0, rdBusy[3][2]}, 32'd1);
    endCycle();
    applyStimulus("wr20rsv21", 1'b1, 5'd20, 32'd7, 1'b1, 5'd21, 5'd20, 5'd21, 5'd19);
    endCycle();
    applyStimulus("rd2021", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd20, 5'd21, 5'd20);
    checkOutput("r20 free", {31'b0, rdBusy[1][0]}, 32'd0);
    checkOutput("r20 data", portData(1, 0), 32'd7);
    checkOutput("r21 busy", {31'b0, rdBusy[1][1]}, 32'd1);
    endCycle();
    applyStimulus("free19", 1'b1, 5'd19, 32'd6, 1'b0, 5'd0, 5'd19, 5'd21, 5'd0);
    endCycle();
    applyStimulus("free21", 1'b1, 5'd21, 32'd8, 1'b0, 5'd0, 5'd19, 5'd21, 5'd0);
    endCycle();

    $display("[TB] zero register write and reserve");
    applyStimulus("wr0", 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0, 5'd0, 5'd21);
    checkOutput("wr0 d0 data", portData(0, 0), 32'd0);
    checkOutput("wr0 d2 busy", {31'b0, rdBusy[2][1]}, 32'd0);
    endCycle();
    applyStimulus("rd0", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    checkOutput("rd0 d0 data", portData(0, 0), 32'd0);
    checkOutput("rd0 d0 busy", {31'b0, rdBusy[0][0]}, 32'd0);
    checkOutput("rd0 d0 any", {31'b0, anyBusy[0]}, 32'd0);
    checkOutput("rd0 d2 any", {31'b0, anyBusy[2]}, 32'd0);
    checkOutput("rd0 d1 data", portData(1, 0), 32'hDEADBEEF);
    endCycle();

    $display("[TB] reset pulse during a pending write and reserve");
    applyStimulus("prerst", 1'b1, 5'd9, 32'h1234, 1'b1, 5'd5, 5'd9, 5'd10, 5'd0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      for (int p = 0; p < NRD; p++) begin
        checkOutput($sformatf("rst d%0d p%0d data", k, p), portData(k, p), 32'd0);
        checkOutput($sformatf("rst d%0d p%0d busy", k, p), {31'b0, rdBusy[k][p]}, 32'd0);
      end
      checkOutput($sformatf("rst d%0d any", k), {31'b0, anyBusy[k]}, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    clearModel();
    rst_n = 1'b1;
    applyStimulus("postrst", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd5, 5'd10);
    endCycle();

    $display("[TB] randomized run");
    for (int c = 0; c < 10000; c++) begin
      logic [4:0] wa = randAddr();
      logic [4:0] ra = ($urandom_range(0, 3) == 0) ? wa : randAddr();
      logic [4:0] a [NRD];
      for (int p = 0; p < NRD; p++) a[p] = ($urandom_range(0, 3) == 0) ? wa : randAddr();
      applyStimulus("rand", 1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 2) == 0),
                    ra, a[0], a[1], a[2]);
      endCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
